tmr_result_unit: RTL and testbench

TMR_RESULT_UNIT -- requirements
Module: tmr_result_unit

---
 rtl/tmr_result_unit_pkg.sv | 16 +
 rtl/tmr_result_unit_lane_cmp.sv | 26 ++
 rtl/tmr_result_unit.sv | 152 +++++++++++++++
 tb/tb_tmr_result_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_result_unit_pkg.sv
// Shared definitions for the TMR result unit: Q6.10 lane format, default lane count
// and the IDLE/SCAN/HOLD state encoding.
package tmr_result_unit_pkg;

    localparam int INT_W      = 6;
    localparam int FRAC_W     = 10;
    localparam int LANE_W_DEF = INT_W + FRAC_W;
    localparam int N_DEF      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/tmr_result_unit_lane_cmp.sv
// Signed greater-than compare of two Q6.10 lanes.
// With RESULT_CLAMP_EN defined, negative operands compare as zero.
module lane_cmp
    import tmr_result_unit_pkg::*;
#(
    parameter int W = LANE_W_DEF
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_gt
);

    logic signed [W-1:0] w_a;
    logic signed [W-1:0] w_b;

`ifdef RESULT_CLAMP_EN
    assign w_a = i_a[W-1] ? '0 : i_a;
    assign w_b = i_b[W-1] ? '0 : i_b;
`else
    assign w_a = i_a;
    assign w_b = i_b;
`endif

    assign o_gt = (w_a > w_b);

endmodule

// File: rtl/tmr_result_unit.sv
// Sequential argmax over an N-lane result vector with a one-entry pending buffer.
// Define RESULT_CLAMP_EN to clamp negative lanes to zero at capture.
module tmr_result_unit
    import tmr_result_unit_pkg::*;
#(
    parameter int  N      = N_DEF,
    parameter int  LANE_W = LANE_W_DEF,
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N*LANE_W-1:0]   Y,
    input  logic                  y_valid,
    input  logic                  res_ready,
    input  logic                  clr_ovr,
    output logic                  res_valid,
    output logic [IDX_W-1:0]      res_class,
    output logic [LANE_W-1:0]     res_value,
    output logic [N*LANE_W-1:0]   res_vec,
    output logic                  busy,
    output logic                  overrun
);

    state_t                r_state;
    state_t                w_state_next;
    logic [N*LANE_W-1:0]   r_work;
    logic [N*LANE_W-1:0]   r_pend;
    logic [N*LANE_W-1:0]   r_res_vec;
    logic [N*LANE_W-1:0]   w_cap_y;
    logic [N*LANE_W-1:0]   w_src;
    logic                  r_pend_full;
    logic                  r_overrun;
    logic [LANE_W-1:0]     r_best;
    logic [LANE_W-1:0]     r_res_value;
    logic [LANE_W-1:0]     w_lane;
    logic [LANE_W-1:0]     w_best_next;
    logic [IDX_W-1:0]      r_best_idx;
    logic [IDX_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_res_class;
    logic [IDX_W-1:0]      w_idx_next;
    logic                  w_hs;
    logic                  w_gt;
    logic                  w_start;
    logic                  w_drop;
    logic                  w_last;
    logic                  w_pend_load;
    logic [LANE_W-1:0]     w_work_lane [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign w_work_lane[gi] = r_work[gi*LANE_W +: LANE_W];
`ifdef RESULT_CLAMP_EN
        assign w_cap_y[gi*LANE_W +: LANE_W] =
            Y[gi*LANE_W + LANE_W - 1] ? '0 : Y[gi*LANE_W +: LANE_W];
`else
        assign w_cap_y[gi*LANE_W +: LANE_W] = Y[gi*LANE_W +: LANE_W];
`endif
    end

    assign w_lane = w_work_lane[r_cnt];

    lane_cmp #(.W(LANE_W)) u_cmp (
        .i_a  (w_lane),
        .i_b  (r_best),
        .o_gt (w_gt)
    );

    assign w_best_next = w_gt ? w_lane : r_best;
    assign w_idx_next  = w_gt ? r_cnt  : r_best_idx;
    assign w_last      = (r_cnt == IDX_W'(N - 1));
    assign w_hs        = (r_state == ST_HOLD) && res_ready;

    // A new scan starts from IDLE, or right after a handshake if anything is waiting.
    assign w_start = ((r_state == ST_IDLE) && y_valid) || (w_hs && (r_pend_full || y_valid));
    assign w_src   = (w_hs && r_pend_full) ? r_pend : w_cap_y;

    // During a handshake the pending slot frees up as its content moves to work.
    assign w_pend_load = y_valid && (r_state != ST_IDLE) && (w_hs ? r_pend_full : !r_pend_full);
    assign w_drop      = y_valid && r_pend_full && !w_hs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (y_valid) w_state_next = ST_SCAN;
            ST_SCAN: if (w_last)  w_state_next = ST_HOLD;
            ST_HOLD: if (w_hs)    w_state_next = (r_pend_full || y_valid) ? ST_SCAN : ST_IDLE;
            default:              w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        res_valid = (r_state == ST_HOLD);
        busy      = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_work      <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_cnt       <= '0;
            r_res_class <= '0;
            r_res_value <= '0;
            r_res_vec   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_start) begin
                r_work     <= w_src;
                r_best     <= w_src[LANE_W-1:0];
                r_best_idx <= '0;
                r_cnt      <= IDX_W'(1);
            end else if (r_state == ST_SCAN) begin
                r_best     <= w_best_next;
                r_best_idx <= w_idx_next;
                r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) begin
                    r_res_class <= w_idx_next;
                    r_res_value <= w_best_next;
                    r_res_vec   <= r_work;
                end
            end

            if (w_pend_load) begin
                r_pend      <= w_cap_y;
                r_pend_full <= 1'b1;
            end else if (w_hs && r_pend_full) begin
                r_pend_full <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign res_class = r_res_class;
    assign res_value = r_res_value;
    assign res_vec   = r_res_vec;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_tmr_result_unit.sv
// Self-checking bench for tmr_result_unit: directed scenarios plus randomized vectors
// checked against a spec-level argmax model (honours RESULT_CLAMP_EN).
module tb_tmr_result_unit;

    localparam int N  = 8;
    localparam int LW = 16;
    localparam int VW = N * LW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [VW-1:0] Y = '0;
    logic          y_valid = 1'b0;
    logic          res_ready = 1'b0;
    logic          clr_ovr = 1'b0;
    logic          res_valid;
    logic [2:0]    res_class;
    logic [LW-1:0] res_value;
    logic [VW-1:0] res_vec;
    logic          busy;
    logic          overrun;

    int tests = 0;
    int fails = 0;

    tmr_result_unit dut (
        .clk       (clk),
        .reset     (reset),
        .Y         (Y),
        .y_valid   (y_valid),
        .res_ready (res_ready),
        .clr_ovr   (clr_ovr),
        .res_valid (res_valid),
        .res_class (res_class),
        .res_value (res_value),
        .res_vec   (res_vec),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack8(input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                                            input logic [LW-1:0] l2, input logic [LW-1:0] l3,
                                            input logic [LW-1:0] l4, input logic [LW-1:0] l5,
                                            input logic [LW-1:0] l6, input logic [LW-1:0] l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    function automatic int lane_int(input logic [VW-1:0] v, input int k);
        logic signed [LW-1:0] s;
        s = v[k*LW +: LW];
        return int'(s);
    endfunction

    // Reference: ReLU (if enabled) applied to every lane of the captured vector.
    function automatic logic [VW-1:0] m_clamp(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
`ifdef RESULT_CLAMP_EN
        for (int k = 0; k < N; k++) begin
            if (lane_int(v, k) < 0) r[k*LW +: LW] = '0;
        end
`endif
        return r;
    endfunction

    // Reference: maximum value, then the lowest lane index holding it.
    function automatic int m_argmax(input logic [VW-1:0] v);
        logic [VW-1:0] c;
        int mx;
        c  = m_clamp(v);
        mx = lane_int(c, 0);
        for (int k = 1; k < N; k++) if (lane_int(c, k) > mx) mx = lane_int(c, k);
        for (int k = 0; k < N; k++) if (lane_int(c, k) == mx) return k;
        return 0;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*LW +: LW] = LW'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            int j;
            j = $urandom_range(1, N - 1);
            v[j*LW +: LW] = v[LW-1:0];
        end
        return v;
    endfunction

    task automatic send(input logic [VW-1:0] v);
        Y       = v;
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
    endtask

    // Returns the cycle index at which res_valid was seen, counting from 'start'.
    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (res_valid !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [VW-1:0] v);
        int            k;
        logic [VW-1:0] c;
        k = m_argmax(v);
        c = m_clamp(v);
        check({tag, "_valid"}, VW'(res_valid), VW'(1));
        check({tag, "_class"}, VW'(res_class), VW'(k));
        check({tag, "_value"}, VW'(res_value), VW'(c[k*LW +: LW]));
        check({tag, "_vec"},   res_vec, c);
    endtask

    task automatic run_vec(input string tag, input logic [VW-1:0] v, input int hold_cycles);
        int lat;
        send(v);
        wait_valid(1, lat);
        check({tag, "_lat"}, VW'(lat), VW'(8));
        check_result(tag, v);
        repeat (hold_cycles) tick();
        check_result({tag, "_held"}, v);
        handshake();
        check({tag, "_idle"}, VW'({res_valid, busy}), VW'(0));
        $display("[TB] %s: class=%0d value=%04h latency=%0d", tag, res_class, res_value, lat);
    endtask

    initial begin
        logic [VW-1:0] va, vb, vc;
        int            lat, d;
        logic          seen;

        // Reset state
        repeat (3) tick();
        check("rst_valid", VW'(res_valid), VW'(0));
        check("rst_busy",  VW'(busy),      VW'(0));
        check("rst_ovr",   VW'(overrun),   VW'(0));
        check("rst_class", VW'(res_class), VW'(0));
        check("rst_value", VW'(res_value), VW'(0));
        check("rst_vec",   res_vec,        VW'(0));
        reset = 1'b1;
        tick();

        // Basic, with res_ready held high throughout
        va = pack8(16'h0400, 16'hFC00, 16'h0C00, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
        res_ready = 1'b1;
        send(va);
        check("basic_scan_valid", VW'(res_valid), VW'(0));
        wait_valid(1, lat);
        check("basic_lat", VW'(lat), VW'(8));
        check_result("basic", va);
        check("basic_class_const", VW'(res_class), VW'(2));
        check("basic_value_const", VW'(res_value), VW'(16'h0C00));
        tick();
        res_ready = 1'b0;
        check("basic_done", VW'({res_valid, busy}), VW'(0));
        $display("[TB] basic: class=%0d value=%04h latency=%0d", res_class, res_value, lat);

        // Tie keeps the lower index; outputs persist after the handshake
        vb = pack8(16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 16'h0000);
        run_vec("tie", vb, 2);
        check("tie_class_const", VW'(res_class), VW'(3));

        // All-negative vector
        vc = pack8(16'h8000, 16'hF000, 16'hFF00, 16'hC000, 16'hFFF0, 16'h8001, 16'hFFFF, 16'hFFFE);
        run_vec("neg", vc, 0);
`ifdef RESULT_CLAMP_EN
        check("neg_class_const", VW'(res_class), VW'(0));
        check("neg_value_const", VW'(res_value), VW'(0));
`else
        check("neg_class_const", VW'(res_class), VW'(6));
        check("neg_value_const", VW'(res_value), VW'(16'hFFFF));
`endif

        // Backpressure: A scanning, B pending, C dropped
        va = pack8(16'h0010, 16'h0700, 16'h0020, 16'h0000, 16'h0030, 16'h0000, 16'h0040, 16'h0000);
        vb = pack8(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0900, 16'h0005, 16'h0006, 16'h0007);
        vc = pack8(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h2000);
        send(va);
        tick();
        send(vb);
        check("bp_no_ovr_yet", VW'(overrun), VW'(0));
        tick();
        send(vc);
        check("bp_ovr_set", VW'(overrun), VW'(1));
        wait_valid(5, lat);
        check("bp_a_lat", VW'(lat), VW'(8));
        check_result("bp_a", va);
        handshake();
        wait_valid(1, lat);
        check("bp_b_lat", VW'(lat), VW'(8));
        check_result("bp_b", vb);
        handshake();
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen = seen | res_valid | busy;
        end
        check("bp_no_c", VW'(seen), VW'(0));
        check("bp_ovr_sticky", VW'(overrun), VW'(1));
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("bp_ovr_clr", VW'(overrun), VW'(0));
        $display("[TB] backpressure: A then B delivered, C dropped");

        // Handshake coincides with y_valid, pending empty
        send(va);
        wait_valid(1, lat);
        Y = vb; y_valid = 1'b1; res_ready = 1'b1;
        tick();
        y_valid = 1'b0; res_ready = 1'b0;
        check("simul_state", VW'({res_valid, busy}), VW'(1));
        wait_valid(1, lat);
        check("simul_lat", VW'(lat), VW'(8));
        check_result("simul", vb);
        handshake();
        $display("[TB] simultaneous: class=%0d latency=%0d", res_class, lat);

        // Handshake coincides with y_valid, pending full: B then C, nothing lost
        send(va);
        tick();
        send(vb);
        wait_valid(3, lat);
        check_result("hsfull_a", va);
        Y = vc; y_valid = 1'b1; res_ready = 1'b1;
        tick();
        y_valid = 1'b0; res_ready = 1'b0;
        wait_valid(1, lat);
        check("hsfull_b_lat", VW'(lat), VW'(8));
        check_result("hsfull_b", vb);
        handshake();
        wait_valid(1, lat);
        check("hsfull_c_lat", VW'(lat), VW'(8));
        check_result("hsfull_c", vc);
        handshake();
        check("hsfull_ovr", VW'(overrun), VW'(0));
        $display("[TB] handshake with pending full: A, B, C delivered");

        // Reset in the middle of SCAN with a pending vector
        send(va);
        tick();
        send(vb);
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_valid", VW'(res_valid), VW'(0));
        check("mid_rst_busy",  VW'(busy),      VW'(0));
        check("mid_rst_class", VW'(res_class), VW'(0));
        check("mid_rst_value", VW'(res_value), VW'(0));
        check("mid_rst_vec",   res_vec,        VW'(0));
        tick();
        tick();
        reset = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen = seen | res_valid | busy;
        end
        check("post_rst_quiet", VW'(seen), VW'(0));
        $display("[TB] reset mid-scan: outputs cleared, no result afterwards");

        // Randomized: pairs of vectors, the second arriving during the first scan
        for (int r = 0; r < 8; r++) begin
            va = rand_vec();
            vb = rand_vec();
            d  = $urandom_range(0, 5);
            send(va);
            repeat (d) tick();
            send(vb);
            wait_valid(d + 2, lat);
            check("rnd_a_lat", VW'(lat), VW'(8));
            check_result("rnd_a", va);
            repeat ($urandom_range(0, 3)) tick();
            check_result("rnd_a_held", va);
            handshake();
            wait_valid(1, lat);
            check("rnd_b_lat", VW'(lat), VW'(8));
            check_result("rnd_b", vb);
            handshake();
            $display("[TB] random %0d: a_class=%0d b_class=%0d", r, m_argmax(va), res_class);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
